// File: rtl/change_dispenser_pkg.sv
// Shared vending definitions: FSM state encoding, coin codes and
// the 5/10/20 denominations used by both the payout and receive sides.
package change_dispenser_pkg;

    localparam int unsigned DENO_5  = 5;
    localparam int unsigned DENO_10 = 10;
    localparam int unsigned DENO_20 = 20;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SELECT,
        ST_DISPENSE,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        COIN_NONE,
        COIN_5,
        COIN_10,
        COIN_20
    } coin_t;

    function automatic int unsigned deno_value(coin_t c);
        unique case (c)
            COIN_5:  return DENO_5;
            COIN_10: return DENO_10;
            COIN_20: return DENO_20;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Coin-ejector handshake: one coin offered at a time with a one-hot
// denomination; master = dispenser, slave = ejector.
interface change_dispenser_if;
    logic coin_valid;
    logic coin_ready;
    logic deno_5;
    logic deno_10;
    logic deno_20;

    modport master (
        output coin_valid, deno_5, deno_10, deno_20,
        input  coin_ready
    );

    modport slave (
        input  coin_valid, deno_5, deno_10, deno_20,
        output coin_ready
    );
endinterface

// File: rtl/change_dispenser.sv
// Greedy change payout FSM: pays change_amt in 20/10/5 coins from stock.
// Ports: clk/reset, start+change_amt, load+stock_in_*, coin handshake
// (interface), busy/done/short_change/remaining, stock_* counts.
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int AMT_W      = 6,
    parameter int STOCK_W    = 4,
    parameter int INIT_STOCK = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [AMT_W-1:0]   change_amt,
    input  logic               load,
    input  logic [STOCK_W-1:0] stock_in_5,
    input  logic [STOCK_W-1:0] stock_in_10,
    input  logic [STOCK_W-1:0] stock_in_20,
    change_dispenser_if.master coin,
    output logic               busy,
    output logic               done,
    output logic               short_change,
    output logic [AMT_W-1:0]   remaining,
    output logic [STOCK_W-1:0] stock_5,
    output logic [STOCK_W-1:0] stock_10,
    output logic [STOCK_W-1:0] stock_20
);

    localparam logic [AMT_W-1:0]   V5   = AMT_W'(DENO_5);
    localparam logic [AMT_W-1:0]   V10  = AMT_W'(DENO_10);
    localparam logic [AMT_W-1:0]   V20  = AMT_W'(DENO_20);
    localparam logic [STOCK_W-1:0] SINIT = STOCK_W'(INIT_STOCK);
    localparam logic [STOCK_W-1:0] SONE  = STOCK_W'(1);

    state_t             state_q;
    coin_t              coin_q;
    coin_t              coin_d;
    logic               valid_q;
    logic               done_q;
    logic               short_q;
    logic [AMT_W-1:0]   rem_q;
    logic [STOCK_W-1:0] s5_q;
    logic [STOCK_W-1:0] s10_q;
    logic [STOCK_W-1:0] s20_q;
    logic [AMT_W-1:0]   val;

    // Greedy pick: largest coin that fits and is still in stock.
    always_comb begin
        coin_d = COIN_NONE;
        if (rem_q >= V20 && s20_q != '0)
            coin_d = COIN_20;
        else if (rem_q >= V10 && s10_q != '0)
            coin_d = COIN_10;
        else if (rem_q >= V5 && s5_q != '0)
            coin_d = COIN_5;
    end

    assign val = AMT_W'(deno_value(coin_q));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            coin_q  <= COIN_NONE;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            short_q <= 1'b0;
            rem_q   <= '0;
            s5_q    <= SINIT;
            s10_q   <= SINIT;
            s20_q   <= SINIT;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        rem_q   <= change_amt;
                        short_q <= 1'b0;
                        state_q <= ST_SELECT;
                    end else if (load) begin
                        s5_q  <= stock_in_5;
                        s10_q <= stock_in_10;
                        s20_q <= stock_in_20;
                    end
                end
                ST_SELECT: begin
                    if (coin_d != COIN_NONE) begin
                        coin_q  <= coin_d;
                        valid_q <= 1'b1;
                        state_q <= ST_DISPENSE;
                    end else begin
                        // done and short_change appear together
                        done_q  <= 1'b1;
                        short_q <= (rem_q != '0);
                        state_q <= ST_DONE;
                    end
                end
                ST_DISPENSE: begin
                    if (coin.coin_ready) begin
                        rem_q <= rem_q - val;
                        unique case (coin_q)
                            COIN_5:  s5_q  <= s5_q - SONE;
                            COIN_10: s10_q <= s10_q - SONE;
                            COIN_20: s20_q <= s20_q - SONE;
                            default: ;
                        endcase
                        coin_q  <= COIN_NONE;
                        valid_q <= 1'b0;
                        state_q <= ST_SELECT;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign coin.coin_valid = valid_q;
    assign coin.deno_5     = (coin_q == COIN_5);
    assign coin.deno_10    = (coin_q == COIN_10);
    assign coin.deno_20    = (coin_q == COIN_20);

    assign busy         = (state_q != ST_IDLE);
    assign done         = done_q;
    assign short_change = short_q;
    assign remaining    = rem_q;
    assign stock_5      = s5_q;
    assign stock_10     = s10_q;
    assign stock_20     = s20_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed self-checking bench for change_dispenser.
// Steps: reset, greedy payouts, shortfall, zero, backpressure, reset.
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [5:0] change_amt;
    logic       load;
    logic [3:0] stock_in_5;
    logic [3:0] stock_in_10;
    logic [3:0] stock_in_20;
    logic       busy;
    logic       done;
    logic       short_change;
    logic [5:0] remaining;
    logic [3:0] stock_5;
    logic [3:0] stock_10;
    logic [3:0] stock_20;

    change_dispenser_if cif ();

    change_dispenser #(
        .AMT_W(6), .STOCK_W(4), .INIT_STOCK(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .change_amt(change_amt),
        .load(load),
        .stock_in_5(stock_in_5),
        .stock_in_10(stock_in_10),
        .stock_in_20(stock_in_20),
        .coin(cif.master),
        .busy(busy),
        .done(done),
        .short_change(short_change),
        .remaining(remaining),
        .stock_5(stock_5),
        .stock_10(stock_10),
        .stock_20(stock_20)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int coins[$];
    int done_cyc;
    int cyc;
    logic [5:0] rem_at_done;
    logic short_at_done;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c);
        @(posedge clk); #1;
        load = 1'b1;
        stock_in_5 = a; stock_in_10 = b; stock_in_20 = c;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    // Launch a transaction with ready held high; collect accepted coins
    // and the cycle (counted from the start edge) where done is seen.
    task automatic run(input logic [5:0] amt);
        coins.delete();
        done_cyc = 0;
        @(posedge clk); #1;
        start = 1'b1; change_amt = amt; cif.coin_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (done_cyc == 0 && cyc < 60) begin
            @(negedge clk);
            if (cif.coin_valid && cif.coin_ready)
                coins.push_back(cif.deno_20 ? 20 : cif.deno_10 ? 10 :
                                cif.deno_5 ? 5 : 0);
            if (done) begin
                done_cyc = cyc;
                rem_at_done = remaining;
                short_at_done = short_change;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (done_cyc == 0) chk("done_timeout", 0, 1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; change_amt = '0; load = 1'b0;
        stock_in_5 = '0; stock_in_10 = '0; stock_in_20 = '0;
        cif.coin_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_valid", cif.coin_valid, 0);
        chk("rst_deno", {cif.deno_20, cif.deno_10, cif.deno_5}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_short", short_change, 0);
        chk("rst_rem", remaining, 0);
        chk("rst_stocks", {stock_20, stock_10, stock_5}, 12'h444);

        // 35 from 4/4/4 -> 20,10,5
        run(6'd35);
        chk("t1_ncoins", coins.size(), 3);
        if (coins.size() == 3) begin
            chk("t1_c0", coins[0], 20);
            chk("t1_c1", coins[1], 10);
            chk("t1_c2", coins[2], 5);
        end
        chk("t1_done_cyc", done_cyc, 8);
        chk("t1_rem", rem_at_done, 0);
        chk("t1_short", short_at_done, 0);
        chk("t1_stocks", {stock_20, stock_10, stock_5}, 12'h333);
        chk("t1_idle", busy, 0);

        // 50 with a single 20 -> 20,10,10,10
        do_load(4'd4, 4'd4, 4'd1);
        chk("t2_load", {stock_20, stock_10, stock_5}, 12'h144);
        run(6'd50);
        chk("t2_ncoins", coins.size(), 4);
        if (coins.size() == 4) begin
            chk("t2_c0", coins[0], 20);
            chk("t2_c1", coins[1], 10);
            chk("t2_c3", coins[3], 10);
        end
        chk("t2_stocks", {stock_20, stock_10, stock_5}, 12'h014);
        chk("t2_short", short_at_done, 0);

        // 15 with only one 10 -> shortfall of 5
        do_load(4'd0, 4'd1, 4'd0);
        run(6'd15);
        chk("t3_ncoins", coins.size(), 1);
        if (coins.size() == 1) chk("t3_c0", coins[0], 10);
        chk("t3_rem", rem_at_done, 5);
        chk("t3_short", short_at_done, 1);
        chk("t3_stock10", stock_10, 0);

        // 7 -> one 5 coin, residue 2; short held afterwards
        do_load(4'd4, 4'd4, 4'd4);
        run(6'd7);
        chk("t4_ncoins", coins.size(), 1);
        if (coins.size() == 1) chk("t4_c0", coins[0], 5);
        chk("t4_rem", rem_at_done, 2);
        chk("t4_short", short_at_done, 1);
        repeat (3) @(posedge clk);
        #1 chk("t4_short_held", short_change, 1);

        // zero amount: no coin, done at T+2, short cleared
        run(6'd0);
        chk("t5_ncoins", coins.size(), 0);
        chk("t5_done_cyc", done_cyc, 2);
        chk("t5_short", short_at_done, 0);

        // backpressure on a 20 coin; start/load during busy ignored
        do_load(4'd4, 4'd4, 4'd4);
        @(posedge clk); #1;
        cif.coin_ready = 1'b0; start = 1'b1; change_amt = 6'd20;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", cif.coin_valid, 1);
            chk("bp_deno", {cif.deno_20, cif.deno_10, cif.deno_5}, 3'b100);
            chk("bp_rem", remaining, 20);
            if (i == 1) begin
                start = 1'b1; change_amt = 6'd63;
                load = 1'b1; stock_in_5 = '0;
                stock_in_10 = '0; stock_in_20 = '0;
            end
            @(posedge clk); #1;
            start = 1'b0; load = 1'b0;
        end
        chk("bp_valid4", cif.coin_valid, 1);
        cif.coin_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_accept", cif.coin_valid, 0);
        chk("bp_rem0", remaining, 0);
        chk("bp_stock20", stock_20, 3);
        @(posedge clk); #1;
        chk("bp_done", done, 1);
        chk("bp_short", short_change, 0);
        @(posedge clk); #1;
        chk("bp_idle", busy, 0);
        chk("bp_noload", {stock_20, stock_10, stock_5}, 12'h344);

        // reset while a 10 coin is in flight
        cif.coin_ready = 1'b0;
        start = 1'b1; change_amt = 6'd10;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("rd_valid", cif.coin_valid, 1);
        chk("rd_deno", {cif.deno_20, cif.deno_10, cif.deno_5}, 3'b010);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rd_valid0", cif.coin_valid, 0);
        chk("rd_deno0", {cif.deno_20, cif.deno_10, cif.deno_5}, 0);
        chk("rd_busy", busy, 0);
        chk("rd_rem", remaining, 0);
        chk("rd_stocks", {stock_20, stock_10, stock_5}, 12'h444);
        for (int i = 0; i < 3; i++) begin
            chk("rd_nodone", done, 0);
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
